pwm_duty_ramp_ctrl: RTL and testbench

//  Soft-start / soft-change controller sitting in front of the 4-bit PWM generator.

---
 rtl/pwm_duty_ramp_ctrl_if.sv | 11 +
 rtl/pwm_duty_ramp_ctrl.sv | 126 ++++++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Host-side target-duty handshake bundle for pwm_duty_ramp_ctrl.
interface pwm_duty_ramp_ctrl_if #(
  parameter int W = 4
);
  logic         set_req;
  logic [W-1:0] set_duty;
  logic         set_ack;

  modport master (output set_req, output set_duty, input  set_ack);
  modport slave  (input  set_req, input  set_duty, output set_ack);
endinterface

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start duty ramp in front of the PWM generator; steps dpwm toward a host target on
// period boundaries. Optional clamp of the target to DUTY_MAX when PWM_DUTY_LIMIT_EN is defined.
module pwm_duty_ramp_ctrl #(
  parameter int W        = 4,
  parameter int PERIOD   = 15,
  parameter int STEP     = 1,
  parameter int RAMP_DIV = 4,
  parameter int DUTY_MAX = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  pwm_duty_ramp_ctrl_if.slave  host,
  output logic [W-1:0]         dpwm,
  output logic                 period_tk,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PERIOD - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(RAMP_DIV - 1);
  localparam logic [W:0]    STEP_X    = (W + 1)'(STEP);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [W-1:0]  dpwm_q, dpwm_d;
  logic [W-1:0]  target_q, target_d;
  logic          period_tk_q, period_tk_d;
  logic          req_seen_q, req_seen_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;

  logic          accept;
  logic          stepped;
  logic [W-1:0]  duty_in;
  logic [W:0]    dp_x, tg_x;
  logic [W:0]    up_sum, dn_dif;
  logic [W-1:0]  up_val, dn_val;

`ifdef PWM_DUTY_LIMIT_EN
  localparam logic [W-1:0] DMAX = W'(DUTY_MAX);
  assign duty_in = (host.set_duty > DMAX) ? DMAX : host.set_duty;
`else
  assign duty_in = host.set_duty;
`endif

  // Step arithmetic in W+1 bits so it saturates at the target instead of wrapping.
  assign dp_x   = {1'b0, dpwm_q};
  assign tg_x   = {1'b0, target_q};
  assign up_sum = dp_x + STEP_X;
  assign dn_dif = dp_x - STEP_X;
  assign up_val = ((tg_x - dp_x) < STEP_X) ? target_q : up_sum[W-1:0];
  assign dn_val = ((dp_x - tg_x) < STEP_X) ? target_q : dn_dif[W-1:0];

  always_comb begin
    pcnt_d      = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + 1'b1;
    period_tk_d = (pcnt_d == PCNT_LAST);
    accept      = host.set_req & ~req_seen_q;
    req_seen_d  = host.set_req;
    ack_d       = accept;
    target_d    = accept ? duty_in : target_q;
    dpwm_d      = dpwm_q;
    rcnt_d      = rcnt_q;
    stepped     = 1'b0;

    // Step decisions use the registered target, so a same-cycle accept applies next clock.
    if (!en) begin
      dpwm_d = '0;
      rcnt_d = '0;
    end else if (state_q != IDLE) begin
      if (period_tk_q) begin
        if (rcnt_q == RCNT_LAST) begin
          rcnt_d  = '0;
          stepped = 1'b1;
          dpwm_d  = (state_q == UP) ? up_val : dn_val;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
    end else begin
      rcnt_d = '0;
    end

    if (!en || (dpwm_d == target_d)) state_d = IDLE;
    else if (dpwm_d < target_d)      state_d = UP;
    else                             state_d = DOWN;

    done_d = stepped && (dpwm_d == target_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pcnt_q      <= '0;
      rcnt_q      <= '0;
      dpwm_q      <= '0;
      target_q    <= '0;
      period_tk_q <= 1'b0;
      req_seen_q  <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      rcnt_q      <= rcnt_d;
      dpwm_q      <= dpwm_d;
      target_q    <= target_d;
      period_tk_q <= period_tk_d;
      req_seen_q  <= req_seen_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
    end
  end

  assign dpwm         = dpwm_q;
  assign period_tk    = period_tk_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign host.set_ack = ack_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed, table-driven bench for pwm_duty_ramp_ctrl (PERIOD=15, STEP=1, RAMP_DIV=4).
module tb_pwm_duty_ramp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] dpwm;
  logic       period_tk, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  pwm_duty_ramp_ctrl_if #(.W(4)) hif ();

  pwm_duty_ramp_ctrl #(
    .W(4), .PERIOD(15), .STEP(1), .RAMP_DIV(4), .DUTY_MAX(12)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .host(hif.slave),
    .dpwm(dpwm), .period_tk(period_tk), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] duty;
    logic [3:0] exp_dpwm;
    bit         exp_done;
    int         exp_steps;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request; ack must appear at the next sample and last exactly one cycle.
  task automatic request(input logic [3:0] d);
    hif.set_req  = 1'b1;
    hif.set_duty = d;
    @(negedge clk);
    chk("ack_pulse", int'(hif.set_ack), 1);
    hif.set_req = 1'b0;
    @(negedge clk);
    chk("ack_width", int'(hif.set_ack), 0);
  endtask

  task automatic run_to_done(input int limit, output int steps, output int bad_tk,
                             output int bad_gap, output bit got_done);
    logic [3:0] prev;
    logic       prev_tk;
    int         last;
    prev = dpwm; prev_tk = period_tk; last = -1;
    steps = 0; bad_tk = 0; bad_gap = 0; got_done = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (dpwm != prev) begin
        steps++;
        if (!prev_tk) bad_tk++;
        if (last >= 0 && (c - last) != 60) bad_gap++;
        last = c;
      end
      prev = dpwm; prev_tk = period_tk;
      if (done) begin got_done = 1'b1; break; end
    end
  endtask

  task automatic wait_dpwm(input logic [3:0] v, input int limit);
    bit found = 1'b0;
    for (int c = 0; c < limit && !found; c++) begin
      @(negedge clk);
      if (dpwm == v) found = 1'b1;
    end
    chk("wait_dpwm", int'(found), 1);
  endtask

  vec_t vecs[4];

  initial begin
    int  steps, bad_tk, bad_gap, acks, extra;
    bit  got_done;
    logic [3:0] lastv;

`ifdef PWM_DUTY_LIMIT_EN
    vecs[0] = '{4'd15, 4'd12, 1'b1, 6};
    vecs[1] = '{4'd3,  4'd3,  1'b1, 9};
`else
    vecs[0] = '{4'd15, 4'd15, 1'b1, 9};
    vecs[1] = '{4'd3,  4'd3,  1'b1, 12};
`endif
    vecs[2] = '{4'd3,  4'd3,  1'b0, 0};
    vecs[3] = '{4'd0,  4'd0,  1'b1, 3};

    reset = 1'b1; en = 1'b0; hif.set_req = 1'b0; hif.set_duty = '0;
    repeat (3) @(negedge clk);
    chk("rst_dpwm", int'(dpwm), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ack",  int'(hif.set_ack), 0);
    chk("rst_tk",   int'(period_tk), 0);
    reset = 1'b0; en = 1'b1;

    // Ramp 0 -> 7: seven unit steps, 60 clocks apart, each right after period_tk.
    hif.set_req = 1'b1; hif.set_duty = 4'd7;
    @(negedge clk);
    chk("ramp7_ack",  int'(hif.set_ack), 1);
    chk("ramp7_busy", int'(busy), 1);
    hif.set_req = 1'b0;
    run_to_done(600, steps, bad_tk, bad_gap, got_done);
    chk("ramp7_done",  int'(got_done), 1);
    chk("ramp7_dpwm",  int'(dpwm), 7);
    chk("ramp7_steps", steps, 7);
    chk("ramp7_tk",    bad_tk, 0);
    chk("ramp7_gap",   bad_gap, 0);
    chk("ramp7_idle",  int'(busy), 0);
    @(negedge clk);
    chk("done_width",  int'(done), 0);

    // Held request gives one ack; re-raise after a low cycle gives another. Same target: no ramp.
    acks = 0; extra = 0;
    hif.set_req = 1'b1; hif.set_duty = 4'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acks += int'(hif.set_ack);
      extra += int'(busy) + int'(done);
    end
    chk("held_acks", acks, 1);
    hif.set_req = 1'b0;
    @(negedge clk);
    acks = 0;
    hif.set_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acks += int'(hif.set_ack);
      extra += int'(busy) + int'(done);
    end
    hif.set_req = 1'b0;
    chk("reraise_acks", acks, 1);
    chk("same_tgt_quiet", extra, 0);

    // Emergency off, then restart ramp toward 7 and retarget to 2 at dpwm=5.
    en = 1'b0;
    @(negedge clk);
    chk("off_dpwm", int'(dpwm), 0);
    chk("off_busy", int'(busy), 0);
    en = 1'b1;
    wait_dpwm(4'd5, 400);
    request(4'd2);
    chk("down_busy", int'(busy), 1);
    lastv = dpwm; extra = 0; got_done = 1'b0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      @(negedge clk);
      if (dpwm != lastv && dpwm != lastv - 4'd1) extra++;
      lastv = dpwm;
      got_done = done;
    end
    chk("down_done",  int'(got_done), 1);
    chk("down_dpwm",  int'(dpwm), 2);
    chk("down_mono",  extra, 0);

    // Drop en at dpwm=6 (ramping to 7), retarget to 6 while off, re-ramp from 0.
    request(4'd7);
    wait_dpwm(4'd6, 400);
    en = 1'b0;
    @(negedge clk);
    chk("off6_dpwm", int'(dpwm), 0);
    chk("off6_busy", int'(busy), 0);
    request(4'd6);
    chk("off6_hold", int'(dpwm), 0);
    en = 1'b1;
    run_to_done(500, steps, bad_tk, bad_gap, got_done);
    chk("re6_done",  int'(got_done), 1);
    chk("re6_dpwm",  int'(dpwm), 6);
    chk("re6_steps", steps, 6);
    chk("re6_gap",   bad_gap, 0);

    for (int i = 0; i < 4; i++) begin
      request(vecs[i].duty);
      if (vecs[i].exp_done) begin
        run_to_done(1300, steps, bad_tk, bad_gap, got_done);
      end else begin
        steps = 0; got_done = 1'b0; lastv = dpwm;
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (done) got_done = 1'b1;
          if (dpwm != lastv) steps++;
          lastv = dpwm;
        end
      end
      chk($sformatf("vec%0d_dpwm", i),  int'(dpwm), int'(vecs[i].exp_dpwm));
      chk($sformatf("vec%0d_done", i),  int'(got_done), int'(vecs[i].exp_done));
      chk($sformatf("vec%0d_steps", i), steps, vecs[i].exp_steps);
      chk($sformatf("vec%0d_tk", i),    bad_tk, 0);
      chk($sformatf("vec%0d_busy", i),  int'(busy), 0);
    end

    // Async reset mid-ramp: outputs clear before the next edge; target is 0 afterwards.
    request(4'd9);
    wait_dpwm(4'd5, 400);
    #2 reset = 1'b1;
    #1;
    chk("arst_dpwm", int'(dpwm), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_tk",   int'(period_tk), 0);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      extra += int'(busy) + int'(dpwm != 4'd0);
    end
    chk("arst_target0", extra, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
